// File: rtl/led_clk_gen.sv
// led_clk_gen: divides clk to a 50%-duty clk_1hz with a rise-aligned tick; a debounced key cycles four speeds.
// Optional macro LED_CLK_PAUSE_EN adds a pause_n input that freezes the divider while low.
module led_clk_gen #(
    parameter int SYS_CLK_HZ   = 50_000_000,
    parameter int BASE_HZ      = 1,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       speed_key,
`ifdef LED_CLK_PAUSE_EN
    input  logic       pause_n,
`endif
    output logic       clk_1hz,
    output logic       tick,
    output logic [1:0] speed_sel
);

    localparam int H0 = SYS_CLK_HZ / (2 * BASE_HZ);
    localparam int CW = $clog2(2 * H0);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] H0_C = CW'(H0);
    localparam logic [CW-1:0] H1_C = CW'(H0 / 2);
    localparam logic [CW-1:0] H2_C = CW'(H0 / 4);
    localparam logic [CW-1:0] H3_C = CW'(2 * H0);

    logic [CW-1:0] cnt;
    logic [CW-1:0] active_half;
    logic [CW-1:0] next_half;
    logic [1:0]    key_sync;
    logic          key_db;
    logic [DW-1:0] db_cnt;
    logic          run;

`ifdef LED_CLK_PAUSE_EN
    logic [1:0] pause_sync;

    // two-flop synchronizer for the pause level; reset as "not paused"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pause_sync <= 2'b11;
        else        pause_sync <= {pause_sync[0], pause_n};
    end

    assign run = pause_sync[1];
`else
    assign run = 1'b1;
`endif

    // half-period selected by the current speed, applied only at a period boundary
    always_comb begin
        next_half = speed_sel == 2'd0 ? H0_C :
                    speed_sel == 2'd1 ? H1_C :
                    speed_sel == 2'd2 ? H2_C : H3_C;
    end

    // divider: toggles clk_1hz every active_half cycles, tick marks the rising toggle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            clk_1hz     <= 1'b0;
            tick        <= 1'b0;
            active_half <= H0_C;
        end else begin
            tick <= 1'b0;
            if (run) begin
                if (cnt == active_half - 1'b1) begin
                    cnt     <= '0;
                    clk_1hz <= ~clk_1hz;
                    tick    <= ~clk_1hz;
                    if (clk_1hz) active_half <= next_half;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // two-flop synchronizer for the raw key; reset as released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) key_sync <= 2'b11;
        else        key_sync <= {key_sync[0], speed_key};
    end

    // debounce: accept a level only after it differs from the held state for DEBOUNCE_CYC cycles; presses advance speed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_db    <= 1'b1;
            db_cnt    <= '0;
            speed_sel <= 2'd0;
        end else if (key_sync[1] == key_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DW'(DEBOUNCE_CYC - 1)) begin
            key_db <= key_sync[1];
            db_cnt <= '0;
            if (!key_sync[1]) speed_sel <= speed_sel + 2'd1;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_led_clk_gen.sv
// tb_led_clk_gen: directed and random key stimulus against an edge-scheduled reference model.
module tb_led_clk_gen;

    localparam int SYS = 40;
    localparam int BASE = 1;
    localparam int DEB = 8;
    localparam int H0 = SYS / (2 * BASE);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       speed_key = 1'b1;
    logic       clk_1hz;
    logic       tick;
    logic [1:0] speed_sel;

    int errors = 0;
    int checks = 0;

    int n;
    int toggle_at;
    int cur_len;
    int m_spd;
    bit m_db;
    bit m_clk;
    bit m_tick;
    bit hist[$];
    int halves[4] = '{H0, H0 / 2, H0 / 4, 2 * H0};

    led_clk_gen #(.SYS_CLK_HZ(SYS), .BASE_HZ(BASE), .DEBOUNCE_CYC(DEB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .speed_key(speed_key),
        .clk_1hz(clk_1hz),
        .tick(tick),
        .speed_sel(speed_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, n, obs, exp);
        end
    endtask

    // reference: absolute edge schedule for toggles, sliding window over sampled key levels
    function automatic void model_reset();
        n = 0;
        cur_len = H0;
        toggle_at = H0;
        hist.delete();
        for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b1);
        m_db = 1'b1;
        m_spd = 0;
        m_clk = 1'b0;
        m_tick = 1'b0;
    endfunction

    function automatic void model_edge(input bit k);
        bit all_diff;
        n++;
        m_tick = 1'b0;
        if (n == toggle_at) begin
            m_clk = !m_clk;
            m_tick = m_clk;
            if (!m_clk) cur_len = halves[m_spd];
            toggle_at = n + cur_len;
        end
        hist.push_back(k);
        if (hist.size() > DEB + 2) void'(hist.pop_front());
        all_diff = 1'b1;
        for (int j = 0; j < DEB; j++) if (hist[j] == m_db) all_diff = 1'b0;
        if (all_diff) begin
            m_db = hist[DEB-1];
            if (!m_db) m_spd = (m_spd + 1) % 4;
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge(speed_key);
        #1;
        chk("clk_1hz", clk_1hz, m_clk);
        chk("tick", tick, m_tick);
        chk("speed_sel", speed_sel, m_spd);
    endtask

    task automatic run(input int cycles, input bit k);
        speed_key = k;
        repeat (cycles) cyc();
    endtask

    task automatic do_reset(input int cycles);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_clk_1hz", clk_1hz, 0);
        chk("rst_tick", tick, 0);
        chk("rst_speed_sel", speed_sel, 0);
        repeat (cycles) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        // free run after reset: first rise at edge H0
        do_reset(2);
        run(H0 - 1, 1'b1);
        chk("pre_first_rise", clk_1hz, 0);
        cyc();
        chk("first_rise", clk_1hz, 1);
        chk("first_tick", tick, 1);
        run(100, 1'b1);

        // clean press in the low phase, then faster periods
        run(5, 1'b1);
        run(20, 1'b0);
        run(40, 1'b1);
        chk("clean_press", speed_sel, 1);

        // bounce shorter than the debounce window, then a solid press
        for (int i = 0; i < 10; i++) run(3, i[0]);
        chk("bounce_no_inc", speed_sel, 1);
        run(20, 1'b0);
        run(20, 1'b1);
        chk("after_bounce", speed_sel, 2);

        // wrap through all four speeds, lingering at the slowest
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            run(12, 1'b0);
            run(20, 1'b1);
            chk("wrap", speed_sel, (i + 1) % 4);
            if (i == 2) run(200, 1'b1);
        end
        run(100, 1'b1);

        // async reset during a high phase at speed 2
        do_reset(2);
        run(12, 1'b0);
        run(20, 1'b1);
        run(12, 1'b0);
        run(20, 1'b1);
        chk("speed_before_rst", speed_sel, 2);
        for (int i = 0; i < 100 && clk_1hz !== 1'b1; i++) cyc();
        chk("high_before_rst", clk_1hz, 1);
        do_reset(3);
        run(H0 - 1, 1'b1);
        chk("post_rst_pre_rise", clk_1hz, 0);
        cyc();
        chk("post_rst_rise", clk_1hz, 1);

        // key held through reset counts as one press
        speed_key = 1'b0;
        do_reset(2);
        run(DEB + 1, 1'b0);
        chk("held_not_yet", speed_sel, 0);
        cyc();
        chk("held_press", speed_sel, 1);
        run(30, 1'b1);

        // random key activity
        for (int i = 0; i < 250; i++) run($urandom_range(1, 25), 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
